// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, sequencer state encoding
// and the rd-writer classification used by the control path.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } seq_state_t;

    function automatic logic writes_rd(input logic [6:0] opc);
        logic w;
        case (opc)
            OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: w = 1'b1;
            default:                      w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/seq_opcode_class.sv
// Combinational opcode classifier feeding the sequencer's DECODE step:
// legality, memory access, rd write and SYSTEM (ECALL/EBREAK) detection.
module seq_opcode_class
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       legal_o,
    output logic       is_mem_o,
    output logic       writes_rd_o,
    output logic       is_system_o
);

    // Sort the opcode into the classes the sequencer branches on
    always_comb begin
        legal_o     = 1'b1;
        is_mem_o    = 1'b0;
        is_system_o = 1'b0;
        case (opcode_i)
            OPC_LOAD, OPC_STORE: is_mem_o = 1'b1;
            OPC_SYSTEM:          is_system_o = 1'b1;
            OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP,
            OPC_OPIMM, OPC_LUI, OPC_AUIPC: legal_o = 1'b1;
            default:             legal_o = 1'b0;
        endcase
    end

    assign writes_rd_o = writes_rd(opcode_i);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Optional fetch/memory wait watchdog: define SEQ_WATCHDOG_EN.
module core_sequencer
    import riscv_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             imem_req,
    output logic             ir_en,
    output logic             dmem_req,
    output logic             reg_we_en,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    seq_state_t       state_q, state_d;
    logic             trap_q;
    logic [CNT_W-1:0] instret_q;
    logic             is_mem_q;
    logic             wr_rd_q;

    logic legal, is_mem, wr_rd, is_sys;
    logic wd_expired;

    seq_opcode_class u_class (
        .opcode_i    (opcode),
        .legal_o     (legal),
        .is_mem_o    (is_mem),
        .writes_rd_o (wr_rd),
        .is_system_o (is_sys)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wait_q, wait_d;

    assign wd_expired = (wait_q == WD_W'(TIMEOUT - 1));

    // Count consecutive cycles spent waiting in FETCH or MEM
    always_comb begin
        wait_d = '0;
        if ((state_d == state_q) &&
            (state_q == S_FETCH || state_q == S_MEM)) begin
            wait_d = wait_q + WD_W'(1);
        end
    end

    // Wait counter register, cleared on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign wd_expired     = 1'b0;
`endif

    // State register and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_q | (state_d == S_TRAP);
        end
    end

    // Retire counter and instruction class captured at DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
            is_mem_q  <= 1'b0;
            wr_rd_q   <= 1'b0;
        end else begin
            if (state_q == S_DECODE) begin
                is_mem_q <= is_mem;
                wr_rd_q  <= wr_rd;
            end
            if ((state_q == S_WB) ||
                (state_q == S_DECODE && legal && is_sys)) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready)      state_d = S_DECODE;
                else if (wd_expired) state_d = S_TRAP;
            end
            S_DECODE: begin
                if (!legal)      state_d = S_TRAP;
                else if (is_sys) state_d = S_HALT;
                else             state_d = S_EXEC;
            end
            S_EXEC:   state_d = is_mem_q ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready)      state_d = S_WB;
                else if (wd_expired) state_d = S_TRAP;
            end
            S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
            S_HALT:   if (resume) state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
        endcase
    end

    // Output strobes decoded from state; ir_en also needs imem_ready
    always_comb begin
        imem_req  = (state_q == S_FETCH);
        ir_en     = (state_q == S_FETCH) && imem_ready;
        dmem_req  = (state_q == S_MEM);
        pc_en     = (state_q == S_WB);
        reg_we_en = (state_q == S_WB) && wr_rd_q;
        halted    = (state_q == S_HALT);
    end

    assign state   = state_q;
    assign trap    = trap_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: table of instructions run
// through a retire scoreboard, plus halt/trap/reset/watchdog sequences.
module tb_core_sequencer;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        halt_req;
    logic        resume;
    logic        imem_req;
    logic        ir_en;
    logic        dmem_req;
    logic        reg_we_en;
    logic        pc_en;
    logic [2:0]  state;
    logic        halted;
    logic        trap;
    logic [31:0] instret;

    core_sequencer #(.CNT_W(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .halt_req   (halt_req),
        .resume     (resume),
        .imem_req   (imem_req),
        .ir_en      (ir_en),
        .dmem_req   (dmem_req),
        .reg_we_en  (reg_we_en),
        .pc_en      (pc_en),
        .state      (state),
        .halted     (halted),
        .trap       (trap),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  opc;
        int          dwait;
        logic        we;
        int          cyc;
        int          memc;
        logic [31:0] trace;
    } rec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] cnt;
    } sb_t;

    int          checks;
    int          failures;
    logic [31:0] exp_instret;
    sb_t         sb[$];
    rec_t        tbl[10];
    rec_t        hrec;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Retire monitor: each WB pops the expected record
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pc_en === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_retire", 32'(sb.size()), 1);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_reg_we_en", 32'(reg_we_en), 32'(e.we));
                    chk("sb_instret", instret, e.cnt);
                end
            end
            if (reg_we_en === 1'b1) begin
                chk("we_outside_wb", 32'(pc_en), 1);
            end
        end
    end

    task automatic wait_fetch(input int budget);
        int n;
        n = 0;
        while (state !== 3'd1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_fetch", 32'(state), 1);
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_to_fetch", 32'(state), 1);
    endtask

    task automatic run_instr(input rec_t r, input bit hlt);
        int          cyc;
        int          memc;
        int          reqc;
        int          irc;
        logic [31:0] tr;
        bit          done;
        cyc  = 0;
        memc = 0;
        reqc = 0;
        irc  = 0;
        tr   = '0;
        done = 1'b0;
        chk({r.name, "_start"}, 32'(state), 1);
        opcode = r.opc;
        sb.push_back('{we: r.we, cnt: exp_instret});
        exp_instret = exp_instret + 1;
        while (!done && cyc < 40) begin
            imem_ready = (state == 3'd1);
            dmem_ready = (state == 3'd4) && (memc == r.dwait);
            if (hlt && state == 3'd3) halt_req = 1'b1;
            #1;
            if (state == 3'd4) begin
                memc++;
                if (dmem_req) reqc++;
            end
            if (ir_en) irc++;
            tr = {tr[27:0], 1'b0, state};
            if (pc_en) done = 1'b1;
            cyc++;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk({r.name, "_done"}, 32'(done), 1);
        chk({r.name, "_cycles"}, 32'(cyc), 32'(r.cyc));
        chk({r.name, "_trace"}, tr, r.trace);
        chk({r.name, "_mem_cycles"}, 32'(memc), 32'(r.memc));
        chk({r.name, "_dmem_req"}, 32'(reqc), 32'(r.memc));
        chk({r.name, "_ir_en"}, 32'(irc), 1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_instret = '0;
        rst_n       = 1'b0;
        opcode      = 7'b0;
        imem_ready  = 1'b0;
        dmem_ready  = 1'b0;
        halt_req    = 1'b0;
        resume      = 1'b0;

        tbl[0] = '{"add",   7'b0110011, 0, 1'b1, 4, 0, 32'h1235};
        tbl[1] = '{"lw",    7'b0000011, 3, 1'b1, 8, 4, 32'h12344445};
        tbl[2] = '{"sw",    7'b0100011, 0, 1'b0, 5, 1, 32'h12345};
        tbl[3] = '{"beq",   7'b1100011, 0, 1'b0, 4, 0, 32'h1235};
        tbl[4] = '{"addi",  7'b0010011, 0, 1'b1, 4, 0, 32'h1235};
        tbl[5] = '{"lui",   7'b0110111, 0, 1'b1, 4, 0, 32'h1235};
        tbl[6] = '{"auipc", 7'b0010111, 0, 1'b1, 4, 0, 32'h1235};
        tbl[7] = '{"jal",   7'b1101111, 0, 1'b1, 4, 0, 32'h1235};
        tbl[8] = '{"jalr",  7'b1100111, 0, 1'b1, 4, 0, 32'h1235};
        tbl[9] = '{"sw_w2", 7'b0100011, 2, 1'b0, 7, 3, 32'h1234445};

        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_instret", instret, 0);
        chk("rst_strobes",
            32'({imem_req, ir_en, dmem_req, reg_we_en, pc_en, halted}), 0);

        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_after_rst", 32'(state), 0);
        @(negedge clk);
        chk("idle_to_fetch", 32'(state), 1);

        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i], 1'b0);
        end
        chk("instret_after_table", instret, exp_instret);

        hrec = tbl[0];
        hrec.name = "add_halt";
        run_instr(hrec, 1'b1);
        chk("halt_state", 32'(state), 6);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_strobes",
            32'({imem_req, ir_en, dmem_req, reg_we_en, pc_en}), 0);
        halt_req = 1'b0;
        pulse_resume();
        run_instr(tbl[0], 1'b0);

        run_instr(hrec, 1'b1);
        chk("rehalt_state", 32'(state), 6);
        pulse_resume();
        run_instr(hrec, 1'b0);
        chk("rehalt_after_instr", 32'(state), 6);
        halt_req = 1'b0;
        pulse_resume();

        opcode     = 7'b1110011;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("sys_decode", 32'(state), 2);
        @(negedge clk);
        exp_instret = exp_instret + 1;
        chk("sys_halt", 32'(state), 6);
        chk("sys_halted", 32'(halted), 1);
        chk("sys_instret", instret, exp_instret);
        pulse_resume();

        opcode     = 7'b0000011;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_in_mem", 32'(state), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_pc_en", 32'({pc_en, reg_we_en}), 0);
        chk("mid_rst_instret", instret, 0);
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch(5);

        opcode     = 7'b1111111;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("ill_decode_trap", 32'(trap), 0);
        @(negedge clk);
        chk("ill_state", 32'(state), 7);
        chk("ill_trap", 32'(trap), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ill_hold",
                32'({state, trap, imem_req, ir_en, pc_en, dmem_req}),
                32'({3'd7, 1'b1, 4'b0000}));
        end
        imem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ill_rst_trap", 32'(trap), 0);
        chk("ill_rst_state", 32'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch(5);

`ifdef SEQ_WATCHDOG_EN
        repeat (15) @(negedge clk);
        chk("wd_before", 32'({state, trap}), 32'({3'd1, 1'b0}));
        @(negedge clk);
        chk("wd_trap_state", 32'(state), 7);
        chk("wd_trap", 32'(trap), 1);
`else
        repeat (100) @(negedge clk);
        chk("nowd_state", 32'(state), 1);
        chk("nowd_trap", 32'(trap), 0);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
